param_sort_engine: RTL
======================

Name: param_sort_engine

Overview:
- Parametrised successor to the team's fixed 6-entry sorter.
- Holds N {data, flag} records and sorts them in place with an odd-even transposition network, one compare-exchange phase per clock.
- Adds runtime ascending/descending mode, a runtime valid-count `num`, and replace-last-and-resort updates.
- Feeds the ranking/selection stage; `flag` travels with its `data` as an opaque tag.

Parameters:
- N, 6, number of record slots (N ≥ 1).
- DATA_W, 8, sort key width, unsigned.
- FLAG_W, 6, tag width carried with each key.
- NUM_W, $clog2(N+1), width of `num`.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- unsort_data  input  N*DATA_W  load keys; slot 0 in the MSBs.
- unsort_flag  input  N*FLAG_W  load tags; slot 0 in the MSBs.
- set  input  1  load all slots and start a sort.
- num  input  NUM_W  valid-record count, sampled on set/update.
- descend  input  1  0 = ascending, 1 = descending; sampled on set/update.
- update_data  input  DATA_W  replacement key.
- update_flag  input  FLAG_W  replacement tag.
- update_en  input  1  replace last valid record and resort.
- done  output  1  sort complete, outputs stable.
- sorted_data  output  N*DATA_W  sorted keys; slot 0 in the MSBs.
- sorted_flag  output  N*FLAG_W  sorted tags; slot 0 in the MSBs.

Behaviour:
- **Reset (async, rst=1):**
  - All slot registers, the phase counter and stored num/descend clear to 0.
  - done=0; state IDLE; sorted_data=0, sorted_flag=0.
- **States:** IDLE → SORT → DONE.
  - set in any state → SORT; set has priority over update_en.
  - update_en is honoured only in DONE (DONE → SORT).
  - update_en in IDLE or SORT is ignored.
- **Load (set at edge E0):**
  - All N slots take the unsort values.
  - num_q = min(num, N); desc_q = descend; phase counter = 0; done=0.
- **Update (update_en at edge E0, state DONE):**
  - Slot num_q'−1 takes {update_data, update_flag}, where num_q' = min(num, N) is the newly sampled value.
  - descend is resampled; phase counter = 0; done=0.
  - If num_q' = 0, no write is made and done is set at E0+1.
- **Phase p (edge E0+p, p = 1..N):**
  - Odd p compares pairs (0,1), (2,3), ...; even p compares pairs (1,2), (3,4), ...
  - A pair (i, i+1) is compared only if i+1 < num_q.
  - Ascending: swap the full records (key and tag) if key[i] > key[i+1]. Descending: swap if key[i] < key[i+1].
  - Equal keys never swap, so the sort is stable.
- **Completion and latency:**
  - done goes high at edge E0+N (N cycles latency); state DONE.
  - done stays high until the next accepted set/update.
- **Outputs:**
  - Slot i drives its register value when i < num_q; otherwise it drives 0 (data and flag).
  - Outputs are combinational from the slot registers and may change during SORT.
- **Boundary cases:**
  - num = 0 or 1: no swaps occur; done still follows the latency rule.
  - num > N: clamped to N.
  - set during SORT: restarts from E0.
  - rst mid-sort: immediate clear; no partial results are retained.

Optional Feature:
- Macro SORT_EARLY_DONE_EN.
- Defined:
  - A swap-seen flag is kept per phase.
  - If two consecutive phases (p ≥ 2) perform zero swaps, done is set at that edge and the engine enters DONE. The result is identical.
  - The N-phase cap still applies.
- Undefined: done is always set exactly at E0+N.

Test Plan:
- **Reset:** assert rst mid-sort → done=0 and all outputs 0 immediately, with no clock required.
- **Ascending load:**
  - Stimulus: N=6, set, num=6, descend=0, data 1,5,6,2,3,4, flags 000001,000010,000100,001000,010000,100000.
  - Expected: done at E0+6; data 1,2,3,4,5,6; flags 000001,001000,010000,100000,000010,000100.
- **Update:**
  - Stimulus: after the ascending load, update_en with num=5, data=10, flag=111111.
  - Expected: data 1,2,3,4,10,0; flags 000001,001000,010000,100000,111111,000000; done at +6.
- **Descending load:** set with descend=1 and the same data → 6,5,4,3,2,1 with tags following their keys; equal keys 7,7 with tags A,B keep order A,B.
- **Priority and clamping:**
  - set and update_en in the same cycle → load wins.
  - update_en during SORT → ignored.
  - num=7 with N=6 → treated as 6.
- **SORT_EARLY_DONE_EN:** set with already-sorted 1..6 → done at E0+2 (with macro) vs E0+6 (without); identical outputs.

Source files
------------

// File: rtl/param_sort_engine.sv
// In-place odd-even transposition sorter for N {data, flag} records, one phase per clock.
// Optional macro SORT_EARLY_DONE_EN: finish once two consecutive phases make no swap.
module param_sort_engine #(
    parameter int unsigned N      = 6,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FLAG_W = 6,
    parameter int unsigned NUM_W  = $clog2(N + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N*DATA_W-1:0] unsort_data,
    input  logic [N*FLAG_W-1:0] unsort_flag,
    input  logic                set,
    input  logic [NUM_W-1:0]    num,
    input  logic                descend,
    input  logic [DATA_W-1:0]   update_data,
    input  logic [FLAG_W-1:0]   update_flag,
    input  logic                update_en,
    output logic                done,
    output logic [N*DATA_W-1:0] sorted_data,
    output logic [N*FLAG_W-1:0] sorted_flag
);

    localparam int unsigned PH_W = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StSort, StDone} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_data [N];
    logic [FLAG_W-1:0]   r_flag [N];
    logic [DATA_W-1:0]   w_data_ph [N];
    logic [FLAG_W-1:0]   w_flag_ph [N];
    logic [NUM_W-1:0]    r_num;
    logic [NUM_W-1:0]    w_num_clamp;
    logic                r_desc;
    logic [PH_W-1:0]     r_phase;
    logic                r_zero_upd;
    logic                w_swapped;
    logic                w_finish;
    logic                w_load;
    logic                w_upd;
`ifdef SORT_EARLY_DONE_EN
    logic                r_prev_quiet;
`endif

    assign w_num_clamp = (num > NUM_W'(N)) ? NUM_W'(N) : num;
    assign w_load      = set;
    assign w_upd       = update_en && !set && (r_state == StDone);

    // r_phase holds p-1 for the phase applied at the next edge: even value -> odd phase.
    always_comb begin
        w_data_ph = r_data;
        w_flag_ph = r_flag;
        w_swapped = 1'b0;
        for (int i = 0; i < int'(N) - 1; i++) begin
            if ((i[0] == r_phase[0]) && (NUM_W'(i + 1) < r_num)) begin
                if (r_desc ? (r_data[i] < r_data[i+1]) : (r_data[i] > r_data[i+1])) begin
                    w_data_ph[i]   = r_data[i+1];
                    w_data_ph[i+1] = r_data[i];
                    w_flag_ph[i]   = r_flag[i+1];
                    w_flag_ph[i+1] = r_flag[i];
                    w_swapped      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_finish = r_zero_upd || (r_phase == PH_W'(N - 1));
`ifdef SORT_EARLY_DONE_EN
        if ((r_phase != '0) && !w_swapped && r_prev_quiet) begin
            w_finish = 1'b1;
        end
`endif
    end

    always_comb begin
        w_state_next = r_state;
        if (w_load || w_upd) begin
            w_state_next = StSort;
        end else if ((r_state == StSort) && w_finish) begin
            w_state_next = StDone;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) begin
                r_data[i] <= '0;
                r_flag[i] <= '0;
            end
            r_num      <= '0;
            r_desc     <= 1'b0;
            r_phase    <= '0;
            r_zero_upd <= 1'b0;
`ifdef SORT_EARLY_DONE_EN
            r_prev_quiet <= 1'b0;
`endif
        end else if (w_load) begin
            for (int i = 0; i < int'(N); i++) begin
                r_data[i] <= unsort_data[(int'(N) - 1 - i) * int'(DATA_W) +: DATA_W];
                r_flag[i] <= unsort_flag[(int'(N) - 1 - i) * int'(FLAG_W) +: FLAG_W];
            end
            r_num      <= w_num_clamp;
            r_desc     <= descend;
            r_phase    <= '0;
            r_zero_upd <= 1'b0;
`ifdef SORT_EARLY_DONE_EN
            r_prev_quiet <= 1'b0;
`endif
        end else if (w_upd) begin
            // Replace the last valid record; an empty set writes nothing and finishes next edge.
            for (int i = 0; i < int'(N); i++) begin
                if ((w_num_clamp != '0) && (NUM_W'(i) == w_num_clamp - NUM_W'(1))) begin
                    r_data[i] <= update_data;
                    r_flag[i] <= update_flag;
                end
            end
            r_num      <= w_num_clamp;
            r_desc     <= descend;
            r_phase    <= '0;
            r_zero_upd <= (w_num_clamp == '0);
`ifdef SORT_EARLY_DONE_EN
            r_prev_quiet <= 1'b0;
`endif
        end else if (r_state == StSort) begin
            r_data  <= w_data_ph;
            r_flag  <= w_flag_ph;
            r_phase <= r_phase + PH_W'(1);
`ifdef SORT_EARLY_DONE_EN
            r_prev_quiet <= !w_swapped;
`endif
        end
    end

    assign done = (r_state == StDone);

    always_comb begin
        sorted_data = '0;
        sorted_flag = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (NUM_W'(i) < r_num) begin
                sorted_data[(int'(N) - 1 - i) * int'(DATA_W) +: DATA_W] = r_data[i];
                sorted_flag[(int'(N) - 1 - i) * int'(FLAG_W) +: FLAG_W] = r_flag[i];
            end
        end
    end

endmodule
